// File: rtl/multicycle_control.sv
// multicycle_control
// Main control FSM for a multicycle MIPS datapath. Sequences the shared ALU,
// memory and register file through FETCH/DECODE/EXECUTE/MEM/WB states. It
// drives every datapath mux select and write enable, and decodes funct into
// the ALU control code during R-type execution.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   op, funct             instruction[31:26] / instruction[5:0] from the IR
//   zero                  ALU zero flag (used in BEQEX)
//   mem_ready             memory completed the current access this cycle
//   iord                  memory address sel: 0=PC, 1=ALUOut
//   alu_src_a             ALU A sel: 0=PC, 1=reg A
//   alu_src_b             ALU B sel: 00=B, 01=4, 10=signimm, 11=signimm<<2
//   pc_src                PC sel: 00=ALUResult, 01=ALUOut, 10=jump target
//   mem_to_reg, reg_dst   register file write-data / write-address sels
//   ir_write, mem_write, reg_write, pc_en   write enables
//   alu_control           010 add, 110 sub, 000 and, 001 or, 111 slt
//   illegal_op            one-cycle pulse in DECODE on an unsupported opcode
//   state                 current state encoding (debug)
module multicycle_control #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       pc_en,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state_q, state_d;
  logic       ready;
  logic       pc_write;
  logic       branch;

  // With the handshake disabled every memory access completes in one cycle.
  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state = state_q;

  function automatic logic [2:0] alu_from_funct(input logic [5:0] f);
    case (f)
      6'b100000: alu_from_funct = ALU_ADD;
      6'b100010: alu_from_funct = ALU_SUB;
      6'b100100: alu_from_funct = ALU_AND;
      6'b100101: alu_from_funct = ALU_OR;
      6'b101010: alu_from_funct = ALU_SLT;
      default:   alu_from_funct = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    iord        = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    alu_control = ALU_AND;
    illegal_op  = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = ready;
        pc_write    = ready;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
          default:                                       illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a   = 1'b1;
        alu_control = alu_from_funct(funct);
      end
      S_RTYPEWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        branch      = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JEX: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    pc_en = pc_write | (branch & zero);
    // Reset forces FETCH selects and kills every enable, so nothing is
    // written during the reset window regardless of mem_ready/zero.
    if (reset) begin
      iord       = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b01;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      pc_en      = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord, alu_src_a, mem_to_reg, reg_dst;
  logic       ir_write, mem_write, reg_write, pc_en, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int n_chk  = 0;
  int n_pass = 0;

  multicycle_control #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .pc_en(pc_en), .alu_control(alu_control),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] fvec [4];
    int         fexp [4];
    fvec[0] = 6'b100000; fexp[0] = 2;
    fvec[1] = 6'b100010; fexp[1] = 6;
    fvec[2] = 6'b100101; fexp[2] = 1;
    fvec[3] = 6'b111111; fexp[3] = 2;

    reset = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_ir_write", 32'(ir_write), 0);
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_src_b", 32'(alu_src_b), 1);
    chk("rst_wr", 32'({mem_write, reg_write, illegal_op}), 0);
    step();
    step();
    reset = 1'b0;
    settle();
    chk("fetch_ir_write", 32'(ir_write), 1);
    chk("fetch_pc_en", 32'(pc_en), 1);

    // lw: 0,1,2,3,4,0
    op = 6'b100011;
    step(); chk("lw_s1", 32'(state), 1); chk("lw_dec_srcb", 32'(alu_src_b), 3);
    step(); chk("lw_s2", 32'(state), 2);
    chk("lw_adr_sel", 32'({alu_src_a, alu_src_b}), 32'b110);
    step(); chk("lw_s3", 32'(state), 3); chk("lw_rd_iord", 32'(iord), 1);
    chk("lw_rd_rw", 32'(reg_write), 0);
    step(); chk("lw_s4", 32'(state), 4);
    chk("lw_wb", 32'({reg_write, mem_to_reg, reg_dst}), 32'b110);
    step(); chk("lw_s0", 32'(state), 0); chk("lw_fetch_rw", 32'(reg_write), 0);

    // FETCH stalls while memory is not ready
    mem_ready = 1'b0; settle();
    chk("stall_ir_write", 32'(ir_write), 0);
    chk("stall_pc_en", 32'(pc_en), 0);
    step(); chk("stall_hold", 32'(state), 0);
    mem_ready = 1'b1;

    // sw with three not-ready cycles in MEMWR
    op = 6'b101011;
    step(); chk("sw_s1", 32'(state), 1);
    step(); chk("sw_s2", 32'(state), 2);
    step(); chk("sw_s5", 32'(state), 5);
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); settle();
      chk($sformatf("sw_wr%0d_state", i), 32'(state), 5);
      chk($sformatf("sw_wr%0d_mw", i), 32'({mem_write, iord, reg_write}), 32'b110);
      step();
    end
    chk("sw_done", 32'(state), 0);
    chk("sw_done_mw", 32'(mem_write), 0);

    // R-type slt
    op = 6'b000000; funct = 6'b101010;
    step(); chk("r_s1", 32'(state), 1);
    step(); chk("r_s6", 32'(state), 6); chk("r_slt", 32'(alu_control), 7);
    chk("r_ex_sel", 32'({alu_src_a, alu_src_b}), 32'b100);
    step(); chk("r_s7", 32'(state), 7);
    chk("r_wb", 32'({reg_write, reg_dst, mem_to_reg}), 32'b110);
    step(); chk("r_s0", 32'(state), 0);

    // funct table
    for (int i = 0; i < 4; i++) begin
      funct = fvec[i];
      step(); step();
      chk($sformatf("funct%0d_alu", i), 32'(alu_control), fexp[i]);
      step(); step();
    end

    // beq taken then not taken
    op = 6'b000100;
    for (int i = 0; i < 2; i++) begin
      step(); step();
      zero = (i == 0); settle();
      chk($sformatf("beq%0d_state", i), 32'(state), 8);
      chk($sformatf("beq%0d_pc_en", i), 32'(pc_en), (i == 0) ? 1 : 0);
      chk($sformatf("beq%0d_pc_src", i), 32'(pc_src), 1);
      chk($sformatf("beq%0d_alu", i), 32'(alu_control), 6);
      step(); chk($sformatf("beq%0d_s0", i), 32'(state), 0);
    end
    zero = 1'b0;

    // j
    op = 6'b000010;
    step(); step();
    chk("j_state", 32'(state), 11);
    chk("j_pc", 32'({pc_en, pc_src}), 32'b110);
    step(); chk("j_s0", 32'(state), 0);

    // addi
    op = 6'b001000;
    step(); step(); chk("addi_s9", 32'(state), 9);
    chk("addi_ex_sel", 32'({alu_src_a, alu_src_b}), 32'b110);
    step(); chk("addi_s10", 32'(state), 10);
    chk("addi_wb", 32'({reg_write, reg_dst, mem_to_reg}), 32'b100);
    step(); chk("addi_s0", 32'(state), 0);

    // illegal opcode
    op = 6'b111111;
    step(); chk("ill_s1", 32'(state), 1); chk("ill_pulse", 32'(illegal_op), 1);
    chk("ill_en", 32'({ir_write, mem_write, reg_write, pc_en}), 0);
    step(); chk("ill_s0", 32'(state), 0); chk("ill_clear", 32'(illegal_op), 0);

    // reset in the middle of MEMWR
    op = 6'b101011;
    step(); step(); step();
    mem_ready = 1'b0; settle();
    chk("mrst_pre_mw", 32'(mem_write), 1);
    reset = 1'b1; settle();
    chk("mrst_state", 32'(state), 0);
    chk("mrst_mw", 32'(mem_write), 0);
    chk("mrst_pc_en", 32'(pc_en), 0);
    step();
    reset = 1'b0; mem_ready = 1'b1; settle();
    chk("mrst_rel_state", 32'(state), 0);
    chk("mrst_rel_pc_en", 32'(pc_en), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
